// File: rtl/dmem_if.sv
// Load/store request and response signals between the datapath memory port
// and the data-memory responder.
interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  // datapath side: issues requests, consumes responses
  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  // responder side
  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request port, fixed access latency,
// byte/half/word sizing with load extension, alignment and range errors.
//
// state | meaning
// IDLE  | no request in flight, ready to accept
// WAIT  | request captured, latency counter running down
// RESP  | access done on the entry edge, rsp_valid high, may accept again
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic    clk,
  input logic    reset,
  dmem_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [1:0]        cap_size;
  logic              cap_unsigned;
  logic [31:0]       cap_wdata;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              req_ready;
  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [1:0]        acc_size;
  logic              acc_unsigned;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_word;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_data;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic              commit;

  assign req_ready = (state != WAIT);
  assign accept    = bus.req_valid & req_ready;

  // With unit latency the access happens on the accept edge itself, so the
  // access uses the live request; otherwise it uses the captured copy.
  always_comb begin
    if (LATENCY == 1) begin
      acc_addr     = bus.req_addr;
      acc_we       = bus.req_we;
      acc_size     = bus.req_size;
      acc_unsigned = bus.req_unsigned;
      acc_wdata    = bus.req_wdata;
      enter_resp   = accept;
    end else begin
      acc_addr     = cap_addr;
      acc_we       = cap_we;
      acc_size     = cap_size;
      acc_unsigned = cap_unsigned;
      acc_wdata    = cap_wdata;
      enter_resp   = (state == WAIT) && (cnt == '0);
    end
  end

  // Error detection, lane selection, load extension and store byte enables
  always_comb begin
    acc_err = (acc_size == 2'b11)
            | ((acc_size == 2'b01) & acc_addr[0])
            | ((acc_size == 2'b10) & (acc_addr[1:0] != 2'b00))
            | ((acc_addr >> (IDX_W + 2)) != '0);
    idx     = acc_addr[IDX_W+1:2];
    rd_word = mem[idx];
    case (acc_addr[1:0])
      2'b00:   lane_b = rd_word[7:0];
      2'b01:   lane_b = rd_word[15:8];
      2'b10:   lane_b = rd_word[23:16];
      default: lane_b = rd_word[31:24];
    endcase
    lane_h = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_size)
      2'b00: begin
        load_data = acc_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
        be        = 4'b0001 << acc_addr[1:0];
        wd        = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        load_data = acc_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
        be        = acc_addr[1] ? 4'b1100 : 4'b0011;
        wd        = {2{acc_wdata[15:0]}};
      end
      default: begin
        load_data = rd_word;
        be        = 4'b1111;
        wd        = acc_wdata;
      end
    endcase
    commit = enter_resp & acc_we & ~acc_err & ~reset;
  end

  // Storage array; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Request/response FSM with latency down-counter and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= enter_resp;
      if (enter_resp) begin
        rsp_rdata_q <= (acc_we | acc_err) ? 32'b0 : load_data;
        rsp_err_q   <= acc_err;
      end
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            cap_addr     <= bus.req_addr;
            cap_we       <= bus.req_we;
            cap_size     <= bus.req_size;
            cap_unsigned <= bus.req_unsigned;
            cap_wdata    <= bus.req_wdata;
            cnt          <= CNT_INIT;
            state        <= (LATENCY == 1) ? RESP : WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder answering the load/store requests the single-cycle datapath issues (address from the ALU result, store data, read/write select). It adds a valid/ready request handshake, a fixed configurable access latency, byte/halfword/word sizing with load sign extension, and alignment and range error reporting. It sits between the datapath's memory port and a word-organised storage array held inside the block.

## Interface
- ADDR_W, 32, byte-address width of req_addr
- DEPTH_WORDS, 256, number of 32-bit storage words; power of two, ≥ 4
- LATENCY, 2, cycles from request acceptance to response; integer ≥ 1

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_addr  in  ADDR_W  byte address
- req_we  in  1  1 = store, 0 = load (datapath MemRW)
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  request was misaligned, illegal size, or out of range
- busy  out  1  request in flight (state ≠ IDLE)

## Operation
- States: IDLE, WAIT, RESP.
- Handshake: request accepted in any cycle with req_valid & req_ready; all req_* fields captured into registers at that edge.
- req_ready = 1 in IDLE and RESP, 0 in WAIT.
- On accept: if LATENCY = 1 go directly to RESP; else go to WAIT with down-counter loaded to LATENCY−2.
- WAIT: counter decrements each cycle; at counter = 0 transition to RESP.
- Access (memory write commit, read data capture) happens on the edge entering RESP.
- RESP: rsp_valid = 1 for exactly that cycle. If a new request is accepted in RESP, next state follows the accept rule above; otherwise IDLE.
- Error checks on captured request: size 11; half with addr[0] = 1; word with addr[1:0] ≠ 00; addr ≥ 4·DEPTH_WORDS. Error → no memory write, rsp_rdata = 0, rsp_err = 1.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Store: byte writes wdata[7:0] to lane addr[1:0]; half writes wdata[15:0] to lane addr[1]; word writes all 32 bits. Other lanes unchanged.
- Load: select lane as above, then sign- or zero-extend to 32 bits per req_unsigned (ignored for word).
- Successful store: rsp_rdata = 0, rsp_err = 0.
- rsp_rdata and rsp_err hold their last values between responses; meaningful only when rsp_valid = 1.

## Timing
- Reset (sync): state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, req_ready 1 from first cycle after reset. Storage contents not reset.
- req_valid during reset cycle is ignored.
- Accept in cycle T → rsp_valid in cycle T+LATENCY; req_ready low T+1 … T+LATENCY−1.
- Maximum throughput: one request per LATENCY cycles (back-to-back via accept in RESP).
- Store accepted at T is visible to a load accepted at T+LATENCY or later.
- Reset mid-operation: in-flight request discarded; store not committed if reset asserted on or before its commit edge; no rsp_valid produced.
- No combinational path from req_* inputs to any output.

## Test plan
- Reset, then LATENCY=2: store word 0xDEADBEEF to 0x10 at T → rsp_valid at T+2, rsp_err 0; load word 0x10 → rsp_rdata 0xDEADBEEF.
- Byte/half sizing: after above, load byte 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE; store byte 0x55 to 0x11 then load word 0x10 → 0xDEAD55EF; load half 0x12 signed → 0xFFFFDEAD.
- Errors: load half at 0x11, load word at 0x12, size 11, load word at 0x400 (DEPTH 256) → each rsp_err 1, rsp_rdata 0; store word to 0x402 leaves all memory unchanged.
- Back-to-back: req_valid held high with 4 requests → accepts at T, T+2, T+4, T+6; rsp_valid at T+2, T+4, T+6, T+8; req_ready low on odd offsets only.
- LATENCY=1 and LATENCY=4 builds: response exactly 1 and 4 cycles after accept; busy high over the same window.
- Reset in WAIT during a store of 0x12345678 to 0x20 (prior value 0) → no rsp_valid, outputs at reset values, subsequent load of 0x20 returns 0.
